video_dotgen_stream: RTL and testbench

//  Parametrised successor to the PET dot generator. Accepts fetched glyph words via valid/ready

---
 rtl/video_pkg.sv | 15 +
 rtl/video_dotgen_stream_buffer.sv | 36 +++
 rtl/video_dotgen_stream.sv | 177 +++++++++++++++++
 tb/tb_video_dotgen_stream.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the streaming dot generator.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    SHIFT      = 2'd2
  } dotgen_state_e;

  // Counter width for a range 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/video_dotgen_stream_buffer.sv
// One-entry valid/ready holding register for fetched glyph words.
module dotgen_word_buffer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_pop,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_hold_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // No bypass: a word captured here is only visible to the consumer next clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush || i_pop) begin
      r_valid <= 1'b0;
    end else if (i_valid && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_ready      = !r_valid;
  assign o_hold_valid = r_valid;
  assign o_data       = r_data;

endmodule

// File: rtl/video_dotgen_stream.sv
// Serialises buffered glyph words MSB-first with per-char reverse/blink,
// horizontal dot replication, per-line word count and sticky underrun.
module video_dotgen_stream
  import video_pkg::*;
#(
  parameter int CHAR_WIDTH = 8,
  parameter int NUM_CHARS  = 2,
  parameter int H_SCALE    = 1,
  parameter int COUNT_W    = 8
) (
  input  logic                             pixel_clk_i,
  input  logic                             reset_i,
  input  logic                             start_i,
  input  logic [COUNT_W-1:0]               words_per_line_i,
  input  logic                             word_valid_i,
  output logic                             word_ready_o,
  input  logic [CHAR_WIDTH*NUM_CHARS-1:0]  pixels_i,
  input  logic [NUM_CHARS-1:0]             reverse_i,
  input  logic [NUM_CHARS-1:0]             blink_i,
  input  logic                             display_en_i,
  input  logic                             blink_phase_i,
  input  logic                             underrun_clr_i,
  output logic                             video_o,
  output logic                             line_done_o,
  output logic                             underrun_o,
  output logic                             busy_o
);

  localparam int WORD_W    = CHAR_WIDTH * NUM_CHARS;
  localparam int SLOT_CLKS = WORD_W * H_SCALE;
  localparam int CTR_W     = clog2_min1(SLOT_CLKS);
  localparam int REP_W     = clog2_min1(H_SCALE);

  localparam logic [CTR_W-1:0]   CTR_MAX = CTR_W'(SLOT_CLKS - 1);
  localparam logic [CTR_W-1:0]   CTR_ONE = CTR_W'(1);
  localparam logic [REP_W-1:0]   REP_MAX = REP_W'(H_SCALE - 1);
  localparam logic [REP_W-1:0]   REP_ONE = REP_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  typedef struct packed {
    logic [WORD_W-1:0]    pixels;
    logic [NUM_CHARS-1:0] reverse;
    logic [NUM_CHARS-1:0] blink;
    logic                 display_en;
    logic                 blink_phase;
  } glyph_word_t;

  localparam int GW_W = $bits(glyph_word_t);

  // Attributes are folded into the dots once, when the word enters the shifter.
  function automatic logic [WORD_W-1:0] apply_attr(input glyph_word_t w);
    logic [WORD_W-1:0]     d;
    logic [CHAR_WIDTH-1:0] g;
    d = '0;
    for (int c = 0; c < NUM_CHARS; c++) begin
      g = w.pixels[c*CHAR_WIDTH +: CHAR_WIDTH];
      if (w.blink[c] && w.blink_phase) g = '0;
      d[c*CHAR_WIDTH +: CHAR_WIDTH] = (g ^ {CHAR_WIDTH{w.reverse[c]}}) & {CHAR_WIDTH{w.display_en}};
    end
    return d;
  endfunction

  dotgen_state_e      r_state, w_next;
  logic [COUNT_W-1:0] r_remaining;
  logic [CTR_W-1:0]   r_ctr;
  logic [REP_W-1:0]   r_rep;
  logic [WORD_W-1:0]  r_shift;
  logic               r_underrun;
  logic               r_zero_done;

  glyph_word_t w_in_word, w_hold_word;
  logic        w_hold_valid, w_ready;
  logic        w_slot_end, w_abort, w_load_word, w_load_blank, w_line_last, w_start_zero;

  assign w_in_word = '{pixels: pixels_i, reverse: reverse_i, blink: blink_i,
                       display_en: display_en_i, blink_phase: blink_phase_i};

  dotgen_word_buffer #(.W(GW_W)) u_buf (
    .i_clk        (pixel_clk_i),
    .i_rst        (reset_i),
    .i_flush      (w_abort),
    .i_pop        (w_load_word),
    .i_valid      (word_valid_i),
    .o_ready      (w_ready),
    .i_data       (w_in_word),
    .o_hold_valid (w_hold_valid),
    .o_data       (w_hold_word)
  );

  assign w_slot_end   = (r_ctr == CTR_MAX);
  assign w_start_zero = start_i && (words_per_line_i == '0);

  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) w_next = w_start_zero ? IDLE : WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (start_i)           w_next = w_start_zero ? IDLE : WAIT_FIRST;
        else if (w_hold_valid) w_next = SHIFT;
      end
      SHIFT: begin
        if (start_i)                               w_next = w_start_zero ? IDLE : WAIT_FIRST;
        else if (w_slot_end && r_remaining == '0)  w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_abort      = start_i && (r_state != IDLE);
    w_load_word  = 1'b0;
    w_load_blank = 1'b0;
    w_line_last  = 1'b0;
    if (!start_i) begin
      if (r_state == WAIT_FIRST) begin
        w_load_word = w_hold_valid;
      end else if (r_state == SHIFT && w_slot_end && r_remaining != '0) begin
        w_load_word  = w_hold_valid;
        w_load_blank = !w_hold_valid;
      end
    end
    if (r_state == SHIFT && w_slot_end && r_remaining == '0) w_line_last = 1'b1;
  end

  // A blank slot reloads the shifter with zeros so dot timing stays identical.
  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      r_remaining <= '0;
      r_ctr       <= '0;
      r_rep       <= '0;
      r_shift     <= '0;
      r_underrun  <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_start_zero;
      if (start_i)
        r_remaining <= words_per_line_i;
      else if ((w_load_word || w_load_blank) && r_remaining != '0)
        r_remaining <= r_remaining - CNT_ONE;

      if (w_abort) begin
        r_shift <= '0;
        r_ctr   <= '0;
        r_rep   <= '0;
      end else if (w_load_word || w_load_blank) begin
        r_shift <= w_load_word ? apply_attr(w_hold_word) : '0;
        r_ctr   <= '0;
        r_rep   <= '0;
      end else if (r_state == SHIFT && !w_slot_end) begin
        r_ctr <= r_ctr + CTR_ONE;
        if (r_rep == REP_MAX) begin
          r_rep   <= '0;
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
        end else begin
          r_rep <= r_rep + REP_ONE;
        end
      end

      if (w_load_blank)        r_underrun <= 1'b1;
      else if (underrun_clr_i) r_underrun <= 1'b0;
    end
  end

  assign video_o      = (r_state == SHIFT) && r_shift[WORD_W-1];
  assign line_done_o  = w_line_last || r_zero_done;
  assign underrun_o   = r_underrun;
  assign busy_o       = (r_state != IDLE);
  assign word_ready_o = w_ready;

endmodule

// File: tb/tb_video_dotgen_stream.sv
// Directed and randomized checks of video_dotgen_stream against a dot-level reference model.
module tb_video_dotgen_stream;

  localparam int CW   = 8;
  localparam int NC   = 2;
  localparam int WW   = CW * NC;
  localparam int CNTW = 8;

  typedef struct {
    logic [WW-1:0] pix;
    logic [NC-1:0] rev;
    logic [NC-1:0] blk;
    logic          en;
    logic          ph;
  } w_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1, start_i = 1'b0, word_valid_i = 1'b0;
  logic display_en_i = 1'b0, blink_phase_i = 1'b0, underrun_clr_i = 1'b0;
  logic [CNTW-1:0] words_i = '0;
  logic [WW-1:0]   pixels_i = '0;
  logic [NC-1:0]   reverse_i = '0, blink_i = '0;
  logic [1:0] video, done, ready, und, busy;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  w_t wl[4];
  bit pres[4];

  always #5 clk = ~clk;

  video_dotgen_stream #(.CHAR_WIDTH(CW), .NUM_CHARS(NC), .H_SCALE(1), .COUNT_W(CNTW)) dut (
    .pixel_clk_i(clk), .reset_i(reset_i), .start_i(start_i), .words_per_line_i(words_i),
    .word_valid_i(word_valid_i), .word_ready_o(ready[0]), .pixels_i(pixels_i),
    .reverse_i(reverse_i), .blink_i(blink_i), .display_en_i(display_en_i),
    .blink_phase_i(blink_phase_i), .underrun_clr_i(underrun_clr_i), .video_o(video[0]),
    .line_done_o(done[0]), .underrun_o(und[0]), .busy_o(busy[0]));

  video_dotgen_stream #(.CHAR_WIDTH(CW), .NUM_CHARS(NC), .H_SCALE(2), .COUNT_W(CNTW)) dut2 (
    .pixel_clk_i(clk), .reset_i(reset_i), .start_i(start_i), .words_per_line_i(words_i),
    .word_valid_i(word_valid_i), .word_ready_o(ready[1]), .pixels_i(pixels_i),
    .reverse_i(reverse_i), .blink_i(blink_i), .display_en_i(display_en_i),
    .blink_phase_i(blink_phase_i), .underrun_clr_i(underrun_clr_i), .video_o(video[1]),
    .line_done_o(done[1]), .underrun_o(und[1]), .busy_o(busy[1]));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Dot p (0 = leftmost) belongs to char NC-1-p/CW; blink blanks the glyph, reverse inverts, enable gates.
  function automatic logic [WW-1:0] ref_dots(input w_t w);
    logic [WW-1:0] d;
    int c;
    logic g;
    d = '0;
    for (int p = 0; p < WW; p++) begin
      c = (NC - 1) - p / CW;
      g = w.pix[WW-1-p];
      if (w.blk[c] && w.ph) g = 1'b0;
      d[WW-1-p] = w.en & (g ^ w.rev[c]);
    end
    return d;
  endfunction

  function automatic w_t mk(input logic [WW-1:0] pix, input logic [NC-1:0] rev,
                            input logic [NC-1:0] blk, input logic en, input logic ph);
    w_t w;
    w.pix = pix; w.rev = rev; w.blk = blk; w.en = en; w.ph = ph;
    return w;
  endfunction

  function automatic w_t rand_word();
    return mk(WW'($urandom), NC'($urandom), NC'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
  endfunction

  task automatic drive_word(input w_t w);
    pixels_i = w.pix; reverse_i = w.rev; blink_i = w.blk;
    display_en_i = w.en; blink_phase_i = w.ph; word_valid_i = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; start_i = 1'b0; word_valid_i = 1'b0; underrun_clr_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // Preloads slot 0's word, starts an n-word line and compares the dot stream sample by sample.
  task automatic run_line(input int n, input string tag);
    int hs, s, k, i, done_idx;
    int wi[4];
    logic [511:0] ov, ev, und_at;
    logic [WW-1:0] d;
    bit got, any_blank;
    hs = (sel == 1) ? 2 : 1;
    s  = WW * hs;
    k  = 0;
    for (int j = 0; j < 4; j++) begin
      wi[j] = k;
      if (pres[j]) k++;
    end
    ev = '0; ov = '0; und_at = '0; any_blank = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (pres[j]) begin
        d = ref_dots(wl[wi[j]]);
        for (int p = 0; p < WW; p++)
          for (int r = 0; r < hs; r++) ev[1 + j*s + p*hs + r] = d[WW-1-p];
      end else begin
        any_blank = 1'b1;
        und_at[j*s + 1] = 1'b1;
      end
    end
    @(negedge clk);
    drive_word(wl[0]);
    @(negedge clk);
    word_valid_i = 1'b0; start_i = 1'b1; words_i = CNTW'(n);
    got = 1'b0; done_idx = -1; i = 0;
    while (!got && i < 400) begin
      @(negedge clk);
      start_i = 1'b0; word_valid_i = 1'b0; underrun_clr_i = 1'b0;
      ov[i] = video[sel];
      if (done[sel]) begin
        got = 1'b1;
        done_idx = i;
      end
      if (und_at[i]) check({tag, "_und_set_wins"}, 512'(und[sel]), 512'(1));
      for (int j = 1; j < n; j++) begin
        if (pres[j] && i == 1 + (j-1)*s + s/2) drive_word(wl[wi[j]]);
        if (!pres[j] && i == j*s) underrun_clr_i = 1'b1;
      end
      i++;
    end
    check({tag, "_done_seen"}, 512'(got), 512'(1));
    check({tag, "_done_pos"}, 512'(done_idx), 512'(n*s));
    check({tag, "_dots"}, ov, ev);
    check({tag, "_underrun"}, 512'(und[sel]), 512'(any_blank));
    @(negedge clk);
    check({tag, "_idle_after"}, 512'({done[sel], busy[sel]}), 512'(0));
    underrun_clr_i = 1'b1;
    @(negedge clk);
    underrun_clr_i = 1'b0;
    check({tag, "_clr"}, 512'(und[sel]), 512'(0));
  endtask

  initial begin
    bit quiet;
    do_reset();
    check("rst_video", 512'(video[0]), 512'(0));
    check("rst_done", 512'(done[0]), 512'(0));
    check("rst_und", 512'(und[0]), 512'(0));
    check("rst_busy", 512'(busy[0]), 512'(0));
    check("rst_ready", 512'(ready[0]), 512'(1));

    sel = 0;
    pres = '{1, 0, 0, 0};
    wl[0] = mk(16'hA50F, 2'b00, 2'b00, 1'b1, 1'b0);
    run_line(1, "a50f");
    wl[0] = mk(16'h0000, 2'b10, 2'b00, 1'b1, 1'b0);
    run_line(1, "rev10");
    wl[0] = mk(16'h3C5A, 2'b11, 2'b00, 1'b0, 1'b0);
    run_line(1, "en0");
    wl[0] = mk(16'hFFFF, 2'b01, 2'b11, 1'b1, 1'b1);
    run_line(1, "blink_ph1");
    wl[0] = mk(16'hFFFF, 2'b01, 2'b11, 1'b1, 1'b0);
    run_line(1, "blink_ph0");

    do_reset();
    sel = 1;
    wl[0] = mk(16'h8000, 2'b00, 2'b00, 1'b1, 1'b0);
    run_line(1, "hscale2");
    do_reset();
    sel = 0;

    pres = '{1, 0, 1, 0};
    wl[0] = mk(16'hF0C3, 2'b00, 2'b00, 1'b1, 1'b0);
    wl[1] = mk(16'h9A65, 2'b10, 2'b00, 1'b1, 1'b0);
    run_line(3, "underrun");

    // Zero-length line: immediate done pulse, no busy.
    @(negedge clk);
    start_i = 1'b1; words_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    check("zero_done", 512'({done[0], busy[0]}), 512'(2'b10));
    @(negedge clk);
    check("zero_done_gone", 512'(done[0]), 512'(0));

    // Abort mid-line with a word held.
    @(negedge clk);
    drive_word(mk(16'hFFFF, 2'b00, 2'b00, 1'b1, 1'b0));
    @(negedge clk);
    word_valid_i = 1'b0; start_i = 1'b1; words_i = 8'd2;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    drive_word(mk(16'hAAAA, 2'b00, 2'b00, 1'b1, 1'b0));
    @(negedge clk);
    word_valid_i = 1'b0;
    check("abort_held", 512'(ready[0]), 512'(0));
    start_i = 1'b1; words_i = 8'd1;
    @(negedge clk);
    start_i = 1'b0;
    check("abort_state", 512'({ready[0], busy[0], video[0]}), 512'(3'b110));
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done[0] || video[0]) quiet = 1'b0;
    end
    check("abort_no_done", 512'(quiet), 512'(1));

    // Reset in the middle of a line, after an underrun and with a word held.
    do_reset();
    @(negedge clk);
    drive_word(mk(16'hFFFF, 2'b00, 2'b00, 1'b1, 1'b0));
    @(negedge clk);
    word_valid_i = 1'b0; start_i = 1'b1; words_i = 8'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_und", 512'(und[0]), 512'(1));
    drive_word(mk(16'h1234, 2'b00, 2'b00, 1'b1, 1'b0));
    @(negedge clk);
    word_valid_i = 1'b0; reset_i = 1'b1;
    @(negedge clk);
    check("midreset_outs", 512'({video[0], done[0], und[0], busy[0], ready[0]}), 512'(5'b00001));
    reset_i = 1'b0;

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 4);
      pres[0] = 1'b1;
      for (int j = 1; j < 4; j++) pres[j] = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) wl[j] = rand_word();
      run_line(n, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
